// File: rtl/mem_tagged_ctrl_if.sv
// Processor-to-memory request/response bundle for mem_tagged_ctrl.
// master = processor side, slave = memory side.
interface mem_tagged_ctrl_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 4
);
  logic [ADDR_W-1:0] proc2mem_addr;
  logic [DATA_W-1:0] proc2mem_data;
  logic [1:0]        proc2mem_command;
  logic [TAG_W-1:0]  mem2proc_response;
  logic [DATA_W-1:0] mem2proc_data;
  logic [TAG_W-1:0]  mem2proc_tag;

  modport master (
    output proc2mem_addr, proc2mem_data, proc2mem_command,
    input  mem2proc_response, mem2proc_data, mem2proc_tag
  );

  modport slave (
    input  proc2mem_addr, proc2mem_data, proc2mem_command,
    output mem2proc_response, mem2proc_data, mem2proc_tag
  );
endinterface

// File: rtl/mem_tagged_ctrl.sv
// Split-transaction tagged memory model: one request per cycle, tag pool, lowest-tag load return.
// Define MEM_RANDOM_LATENCY_EN to add an LFSR-driven 0..7 cycle extra latency per request.
module mem_tagged_ctrl #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_LINES = 8192,
  parameter int unsigned NUM_TAGS  = 15,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned LATENCY   = 8
) (
  input logic               clock,
  input logic               reset,
  mem_tagged_ctrl_if.slave  bus
);
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8);
  localparam int unsigned LINE_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int unsigned IDX_W  = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int unsigned CNT_W  = $clog2(LATENCY + 8) + 1;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_LINES * (DATA_W / 8));
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  logic [DATA_W-1:0] mem_q  [MEM_LINES];
  logic [DATA_W-1:0] snap_q [NUM_TAGS];
  logic [CNT_W-1:0]  cnt_q  [NUM_TAGS];
  logic [CNT_W-1:0]  cnt_d  [NUM_TAGS];
  logic [NUM_TAGS-1:0] wait_q, wait_d;
  logic [TAG_W-1:0]  resp_q, resp_d, tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [LINE_W-1:0] line_c;
  logic              addr_ok_c, is_load_c, is_store_c, accept_c;
  logic              alloc_ok_c, ret_ok_c;
  logic [IDX_W-1:0]  alloc_idx_c, ret_idx_c;
  logic [CNT_W-1:0]  lat_c;

  assign line_c     = bus.proc2mem_addr[OFF_W +: LINE_W];
  assign addr_ok_c  = (bus.proc2mem_addr[OFF_W-1:0] == '0) && (bus.proc2mem_addr < ADDR_LIMIT);
  assign is_load_c  = (bus.proc2mem_command == CMD_LOAD);
  assign is_store_c = (bus.proc2mem_command == CMD_STORE);

`ifdef MEM_RANDOM_LATENCY_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; free-running every edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign lat_c = CNT_W'(LATENCY) + CNT_W'(lfsr_q[2:0]);
`else
  assign lat_c = CNT_W'(LATENCY);
`endif

  // Tag bookkeeping: counters tick down, pick lowest free tag and lowest eligible return.
  // A load returns on the edge its counter reaches 0 (or later if it lost arbitration).
  always_comb begin
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    resp_d      = '0;
    tag_d       = '0;
    data_d      = '0;
    alloc_ok_c  = 1'b0;
    alloc_idx_c = '0;
    ret_ok_c    = 1'b0;
    ret_idx_c   = '0;
    accept_c    = 1'b0;

    for (int unsigned i = 0; i < NUM_TAGS; i++) begin
      if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_W'(1);
      if (!ret_ok_c && wait_q[i] && (cnt_q[i] <= CNT_W'(1))) begin
        ret_ok_c  = 1'b1;
        ret_idx_c = IDX_W'(i);
      end
      if (!alloc_ok_c && !wait_q[i] && (cnt_q[i] == '0)) begin
        alloc_ok_c  = 1'b1;
        alloc_idx_c = IDX_W'(i);
      end
    end

    accept_c = alloc_ok_c && addr_ok_c && (is_load_c || is_store_c);

    if (ret_ok_c) begin
      wait_d[ret_idx_c] = 1'b0;
      tag_d             = TAG_W'(ret_idx_c) + TAG_W'(1);
      data_d            = snap_q[ret_idx_c];
    end

    if (accept_c) begin
      cnt_d[alloc_idx_c]  = lat_c;
      wait_d[alloc_idx_c] = is_load_c;
      resp_d              = TAG_W'(alloc_idx_c) + TAG_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_TAGS; i++) cnt_q[i] <= '0;
      wait_q <= '0;
      resp_q <= '0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wait_q <= wait_d;
      resp_q <= resp_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  // Array and load snapshots are not reset; the bench preloads the array through stores.
  always_ff @(posedge clock) begin
    if (!reset && accept_c && is_store_c) mem_q[line_c] <= bus.proc2mem_data;
    if (!reset && accept_c && is_load_c)  snap_q[alloc_idx_c] <= mem_q[line_c];
  end

  assign bus.mem2proc_response = resp_q;
  assign bus.mem2proc_tag      = tag_q;
  assign bus.mem2proc_data     = data_q;
endmodule

// File: tb/tb_mem_tagged_ctrl.sv
// Self-checking bench for mem_tagged_ctrl: timestamp/queue reference model, vector table,
// hand sequences (latency, reset mid-flight, tag exhaustion on a 3-tag instance) and random traffic.
module tb_mem_tagged_ctrl;
  localparam int unsigned LAT = 8;
  localparam int unsigned NT  = 15;
  localparam logic [1:0] C_NONE = 2'd0, C_LOAD = 2'd1, C_STORE = 2'd2, C_RSVD = 2'd3;
  localparam logic [63:0] BEEF = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] TOPV = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_tagged_ctrl_if #(.ADDR_W(64), .DATA_W(64), .TAG_W(4)) if1 ();
  mem_tagged_ctrl_if #(.ADDR_W(64), .DATA_W(64), .TAG_W(4)) if2 ();

  mem_tagged_ctrl u_dut (.clock(clk), .reset(rst), .bus(if1));
  mem_tagged_ctrl #(.NUM_TAGS(3)) u_dut3 (.clock(clk), .reset(rst), .bus(if2));

  int n_checks = 0;
  int n_err    = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: each outstanding transaction is a record with a due edge number
  typedef struct {
    int          tag;
    longint      due;
    bit          ld;
    logic [63:0] d;
  } ent_t;

  ent_t        q[$];
  logic [63:0] mem_m [int];
  longint      ecount;
  logic [15:0] m_lfsr;
  logic [63:0] exp_resp, exp_tag, exp_data;

  function automatic void m_reset();
    q.delete();
    exp_resp = '0;
    exp_tag  = '0;
    exp_data = '0;
    m_lfsr   = 16'hACE1;
  endfunction

  function automatic void model_edge(logic [1:0] cmd, logic [63:0] addr, logic [63:0] data);
    int   rt = 0;
    int   t  = 0;
    bit   busy [16];
    int   lat;
    bit   acc;
    ent_t nq[$];
    ent_t e;
    exp_data = '0;
    foreach (q[i]) begin
      busy[q[i].tag] = 1'b1;
      if (q[i].ld && q[i].due <= ecount && (rt == 0 || q[i].tag < rt)) begin
        rt = q[i].tag;
        exp_data = q[i].d;
      end
    end
    exp_tag = 64'(rt);
    for (int k = NT; k >= 1; k--) if (!busy[k]) t = k;
    acc = (cmd == C_LOAD || cmd == C_STORE) && (addr % 8 == 0) && (addr < 64'h10000) && (t != 0);
    exp_resp = acc ? 64'(t) : '0;
`ifdef MEM_RANDOM_LATENCY_EN
    lat = int'(LAT) + int'(m_lfsr[2:0]);
`else
    lat = int'(LAT);
`endif
    foreach (q[i])
      if (!((q[i].ld && q[i].tag == rt) || (!q[i].ld && q[i].due <= ecount))) nq.push_back(q[i]);
    q = nq;
    if (acc) begin
      e.tag = t;
      e.due = ecount + lat;
      e.ld  = (cmd == C_LOAD);
      e.d   = '0;
      if (cmd == C_LOAD) e.d = mem_m.exists(int'(addr >> 3)) ? mem_m[int'(addr >> 3)] : '0;
      else               mem_m[int'(addr >> 3)] = data;
      q.push_back(e);
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    ecount++;
  endfunction

  task automatic drive(logic [1:0] cmd, logic [63:0] addr, logic [63:0] data);
    if1.proc2mem_command = cmd;
    if1.proc2mem_addr    = addr;
    if1.proc2mem_data    = data;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare
  task automatic cycle();
    @(posedge clk);
    if (rst) m_reset();
    else     model_edge(if1.proc2mem_command, if1.proc2mem_addr, if1.proc2mem_data);
    #1;
    check("response", 64'(if1.mem2proc_response), exp_resp);
    check("ret_tag",  64'(if1.mem2proc_tag), exp_tag);
    check("ret_data", if1.mem2proc_data, exp_data);
  endtask

  task automatic do_reset();
    drive(C_NONE, '0, '0);
    if2.proc2mem_command = C_NONE;
    rst = 1'b1;
    m_reset();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [3:0]  exp_resp;
  } vec_t;

  vec_t vt [9];
  bit          seen1;
  logic [63:0] got [5];
  bit          found;
  logic [1:0]  rc;
  logic [63:0] ra;

  initial begin
    vt[0] = '{C_STORE, 64'h20,                  64'h55,  4'd1};
    vt[1] = '{C_LOAD,  64'h20,                  64'h0,   4'd2};
    vt[2] = '{C_LOAD,  64'h13,                  64'h0,   4'd0};
    vt[3] = '{C_STORE, 64'h13,                  64'hBAD, 4'd0};
    vt[4] = '{C_STORE, 64'h10000,               64'hBAD, 4'd0};
    vt[5] = '{C_STORE, 64'h8000_0000_0000_0010, 64'hBAD, 4'd0};
    vt[6] = '{C_RSVD,  64'h28,                  64'h0,   4'd0};
    vt[7] = '{C_LOAD,  64'hFFF8,                64'h0,   4'd3};
    vt[8] = '{C_LOAD,  64'h10,                  64'h0,   4'd4};

    ecount = 0;
    if2.proc2mem_addr = '0;
    if2.proc2mem_data = '0;
    do_reset();

    // preload lines 0..31 and the last line through the store path
    for (int l = 0; l < 32; l++) begin
      drive(C_STORE, 64'(l * 8), (l == 2) ? BEEF : {$urandom, $urandom});
      cycle();
    end
    drive(C_STORE, 64'hFFF8, TOPV);
    cycle();
    drive(C_NONE, '0, '0);
    repeat (12) cycle();

    // single load latency; array survives reset
    do_reset();
    drive(C_LOAD, 64'h10, '0);
    cycle();
    check("t1_resp", 64'(if1.mem2proc_response), 64'd1);
    drive(C_NONE, '0, '0);
    for (int i = 1; i <= 8; i++) begin
      cycle();
`ifndef MEM_RANDOM_LATENCY_EN
      check("t1_tag",  64'(if1.mem2proc_tag), (i == 8) ? 64'd1 : 64'd0);
      check("t1_data", if1.mem2proc_data, (i == 8) ? BEEF : 64'd0);
`endif
    end
    repeat (10) cycle();

    // vector table from a fresh reset
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].cmd, vt[i].addr, vt[i].data);
      cycle();
      check($sformatf("tbl%0d_resp", i), 64'(if1.mem2proc_response), 64'(vt[i].exp_resp));
    end
    drive(C_NONE, '0, '0);
    seen1 = 1'b0;
    for (int i = 0; i < 5; i++) got[i] = 'x;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (if1.mem2proc_tag == 4'd1) seen1 = 1'b1;
      if (if1.mem2proc_tag >= 4'd2 && if1.mem2proc_tag <= 4'd4) got[if1.mem2proc_tag] = if1.mem2proc_data;
    end
    check("store_tag_never_returns", 64'(seen1), 64'd0);
    check("st_ld_forward",  got[2], 64'h55);
    check("last_line_load", got[3], TOPV);
    check("misaligned_store_no_write", got[4], BEEF);

    // 16 back-to-back loads on the full pool (model-checked)
    for (int i = 0; i < 16; i++) begin
      drive(C_LOAD, 64'((i % 32) * 8), '0);
      cycle();
    end
    drive(C_NONE, '0, '0);
    repeat (25) cycle();

    // tag exhaustion on the 3-tag instance
    for (int i = 0; i < 4; i++) begin
      if2.proc2mem_command = C_LOAD;
      if2.proc2mem_addr    = 64'(i * 8);
      cycle();
      check("x3_resp", 64'(if2.mem2proc_response), (i < 3) ? 64'(i + 1) : 64'd0);
    end
    if2.proc2mem_command = C_NONE;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (if2.mem2proc_tag == 4'd1) found = 1'b1;
    end
    check("x3_tag1_returned", 64'(found), 64'd1);
    if2.proc2mem_command = C_LOAD;
    if2.proc2mem_addr    = 64'h40;
    cycle();
    check("x3_realloc", 64'(if2.mem2proc_response), 64'd1);
    if2.proc2mem_command = C_NONE;
    repeat (25) cycle();

    // reset with three loads in flight
    for (int i = 0; i < 3; i++) begin
      drive(C_LOAD, 64'(i * 8), '0);
      cycle();
    end
    drive(C_NONE, '0, '0);
    rst = 1'b1;
    m_reset();
    #1;
    check("arst_resp", 64'(if1.mem2proc_response), 64'd0);
    check("arst_tag",  64'(if1.mem2proc_tag), 64'd0);
    check("arst_data", if1.mem2proc_data, 64'd0);
    cycle();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("post_rst_no_ret", 64'(if1.mem2proc_tag), 64'd0);
    end
    drive(C_LOAD, 64'h8, '0);
    cycle();
    check("post_rst_resp", 64'(if1.mem2proc_response), 64'd1);
    drive(C_NONE, '0, '0);
    repeat (20) cycle();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rc = 2'($urandom_range(0, 3));
      ra = 64'($urandom_range(0, 31) * 8);
      if ($urandom_range(0, 7) == 0)  ra = ra + 64'($urandom_range(1, 7));
      if ($urandom_range(0, 15) == 0) ra = 64'h10000 + ra;
      drive(rc, ra, {$urandom, $urandom});
      cycle();
    end
    drive(C_NONE, '0, '0);
    repeat (30) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
